// File: rtl/fpu_pkg.sv
// Shared types and field constants for the FP issue/writeback slice.
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MOV = 2'b10,
    OP_NEG = 2'b11
  } fpu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_CAPT = 2'b10,
    ST_WB   = 2'b11
  } fpu_state_t;

  localparam int          FP_SIGN     = 31;
  localparam int          FP_EXP_HI   = 30;
  localparam int          FP_EXP_LO   = 23;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

  // A zero biased exponent marks a value the adder cannot treat correctly.
  function automatic logic fp_exp_zero(input logic [31:0] v);
    return (v[FP_EXP_HI:FP_EXP_LO] == 8'h00);
  endfunction

endpackage

// File: rtl/fpu_issue_if.sv
// Request, MTC1/MFC1, adder and writeback-status bundle for fpu_issue.
interface fpu_issue_if #(parameter int AW = 5);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_fs;
  logic [AW-1:0] req_ft;
  logic [AW-1:0] req_fd;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic [31:0]   add_res;
  logic          ext_wr_en;
  logic [AW-1:0] ext_wr_addr;
  logic [31:0]   ext_wr_data;
  logic          ext_wr_ready;
  logic [AW-1:0] ext_rd_addr;
  logic [31:0]   ext_rd_data;
  logic          done;
  logic [AW-1:0] done_fd;
  logic [31:0]   done_data;

  modport master (
    output req_valid, req_op, req_fs, req_ft, req_fd, add_res,
           ext_wr_en, ext_wr_addr, ext_wr_data, ext_rd_addr,
    input  req_ready, add_a, add_b, ext_wr_ready, ext_rd_data,
           done, done_fd, done_data
  );

  modport slave (
    input  req_valid, req_op, req_fs, req_ft, req_fd, add_res,
           ext_wr_en, ext_wr_addr, ext_wr_data, ext_rd_addr,
    output req_ready, add_a, add_b, ext_wr_ready, ext_rd_data,
           done, done_fd, done_data
  );
endinterface

// File: rtl/fp_regfile.sv
// FP register file: one write port (writeback over MTC1), two operand reads
// sampled by the issuer, and an unbypassed MFC1 read.
module fp_regfile #(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [31:0]   wb_data,
  input  logic          ext_en,
  input  logic [AW-1:0] ext_addr,
  input  logic [31:0]   ext_data,
  input  logic [AW-1:0] rd_a_addr,
  output logic [31:0]   rd_a_data,
  input  logic [AW-1:0] rd_b_addr,
  output logic [31:0]   rd_b_data,
  input  logic [AW-1:0] rd_x_addr,
  output logic [31:0]   rd_x_data
);
  logic [31:0]   rf_r [NREG];
  logic          wr_en_s;
  logic [AW-1:0] wr_addr_s;
  logic [31:0]   wr_data_s;

  // Write-port select, writeback first.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = wb_addr;
    wr_data_s = wb_data;
    if (wb_en) begin
      wr_en_s = 1'b1;
    end else if (ext_en) begin
      wr_en_s   = 1'b1;
      wr_addr_s = ext_addr;
      wr_data_s = ext_data;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_r[i] <= 32'h0000_0000;
    end else if (wr_en_s) begin
      rf_r[wr_addr_s] <= wr_data_s;
    end
  end

  assign rd_a_data = rf_r[rd_a_addr];
  assign rd_b_data = rf_r[rd_b_addr];
  assign rd_x_data = rf_r[rd_x_addr];
endmodule

// File: rtl/fpu_issue.sv
// FP issue/writeback sequencer in front of the single-precision adder.
// Optional FPU_ZERO_FLUSH_EN: patch the adder's zero handling for ADD/SUB.
module fpu_issue #(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  fpu_issue_if.slave  bus
);
  import fpu_pkg::*;

  fpu_state_t    state_r, state_nxt_s;
  fpu_op_t       op_r, req_op_s;
  logic [AW-1:0] fd_r, done_fd_r;
  logic [31:0]   add_a_r, add_b_r, res_r, done_data_r;
  logic [31:0]   rd_fs_s, rd_ft_s, fs_val_s, ft_val_s, sum_s, cap_s;
  logic          done_r, accept_s, ext_ok_s, wb_s;

  assign accept_s = bus.req_valid && (state_r == ST_IDLE);
  assign ext_ok_s = bus.ext_wr_en && (state_r != ST_WB);
  assign wb_s     = (state_r == ST_WB);
  assign req_op_s = fpu_op_t'(bus.req_op);

  // An MTC1 landing on the accept edge is forwarded into the operands.
  assign fs_val_s = (ext_ok_s && (bus.ext_wr_addr == bus.req_fs)) ? bus.ext_wr_data : rd_fs_s;
  assign ft_val_s = (ext_ok_s && (bus.ext_wr_addr == bus.req_ft)) ? bus.ext_wr_data : rd_ft_s;

  fp_regfile #(.NREG(NREG), .AW(AW)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_en     (wb_s),
    .wb_addr   (fd_r),
    .wb_data   (res_r),
    .ext_en    (ext_ok_s),
    .ext_addr  (bus.ext_wr_addr),
    .ext_data  (bus.ext_wr_data),
    .rd_a_addr (bus.req_fs),
    .rd_a_data (rd_fs_s),
    .rd_b_addr (bus.req_ft),
    .rd_b_data (rd_ft_s),
    .rd_x_addr (bus.ext_rd_addr),
    .rd_x_data (bus.ext_rd_data)
  );

`ifdef FPU_ZERO_FLUSH_EN
  // Zero-aware override of the adder result on the effective operands.
  always_comb begin
    sum_s = bus.add_res;
    if (fp_exp_zero(add_a_r) && fp_exp_zero(add_b_r)) begin
      sum_s = FP_POS_ZERO;
    end else if (fp_exp_zero(add_a_r)) begin
      sum_s = add_b_r;
    end else if (fp_exp_zero(add_b_r)) begin
      sum_s = add_a_r;
    end else if ((add_a_r[FP_EXP_HI:0] == add_b_r[FP_EXP_HI:0]) &&
                 (add_a_r[FP_SIGN] != add_b_r[FP_SIGN])) begin
      sum_s = FP_POS_ZERO;
    end else begin
      sum_s = bus.add_res;
    end
  end
`else
  assign sum_s = bus.add_res;
`endif

  // Result selection; add_a_r doubles as the latched fs value.
  always_comb begin
    cap_s = sum_s;
    case (op_r)
      OP_ADD, OP_SUB: cap_s = sum_s;
      OP_MOV:         cap_s = add_a_r;
      OP_NEG:         cap_s = {~add_a_r[FP_SIGN], add_a_r[FP_EXP_HI:0]};
      default:        cap_s = sum_s;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_EXEC;
        else          state_nxt_s = ST_IDLE;
      end
      ST_EXEC: state_nxt_s = ST_CAPT;
      ST_CAPT: state_nxt_s = ST_WB;
      ST_WB:   state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Operand latch on accept, capture and writeback status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a_r     <= 32'h0000_0000;
      add_b_r     <= 32'h0000_0000;
      op_r        <= OP_ADD;
      fd_r        <= {AW{1'b0}};
      res_r       <= FP_POS_ZERO;
      done_r      <= 1'b0;
      done_fd_r   <= {AW{1'b0}};
      done_data_r <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        add_a_r <= fs_val_s;
        op_r    <= req_op_s;
        fd_r    <= bus.req_fd;
        case (req_op_s)
          OP_ADD:  add_b_r <= ft_val_s;
          OP_SUB:  add_b_r <= {~ft_val_s[FP_SIGN], ft_val_s[FP_EXP_HI:0]};
          default: add_b_r <= add_b_r;
        endcase
      end
      if (state_r == ST_CAPT) begin
        res_r       <= cap_s;
        done_r      <= 1'b1;
        done_fd_r   <= fd_r;
        done_data_r <= cap_s;
      end else begin
        done_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready    = (state_r == ST_IDLE);
  assign bus.ext_wr_ready = !wb_s;
  assign bus.add_a        = add_a_r;
  assign bus.add_b        = add_b_r;
  assign bus.done         = done_r;
  assign bus.done_fd      = done_fd_r;
  assign bus.done_data    = done_data_r;
endmodule

// File: tb/tb_fpu_issue.sv
// Randomized bench for fpu_issue against a cycle-timed behavioural model.
module tb_fpu_issue;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  fpu_issue_if #(.AW(5)) bif ();

  fpu_issue #(.NREG(32), .AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain truncating FP adder with no zero special-casing.
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b;
    logic [63:0] ma, mb, s;
    int ea, eb, sh, lead, er;
    if (x[30:0] >= y[30:0]) begin a = x; b = y; end
    else begin a = y; b = x; end
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sh = ea - eb;
    ma = {40'd0, 1'b1, a[22:0]} << 24;
    mb = {40'd0, 1'b1, b[22:0]} << 24;
    mb = (sh > 47) ? 64'd0 : (mb >> sh);
    s  = (a[31] == b[31]) ? (ma + mb) : (ma - mb);
    if (s == 64'd0) return 32'h0000_0000;
    lead = 0;
    for (int i = 0; i < 64; i++) if (s[i]) lead = i;
    er = ea + lead - 47;
    s  = s << (63 - lead);
    return {a[31], 8'(er), s[62:40]};
  endfunction

  assign bif.add_res = fadd(bif.add_a, bif.add_b);

  // Expected ADD/SUB result from the effective operands.
  function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
`ifdef FPU_ZERO_FLUSH_EN
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return 32'h0000_0000;
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] == b[30:0] && a[31] != b[31]) return 32'h0000_0000;
`endif
    return fadd(a, b);
  endfunction

  // Model: register contents, operands, and edges since the last accept.
  logic [31:0] m_rf [32];
  int          m_since;
  logic [31:0] m_add_a, m_add_b, m_res, m_done_data;
  logic [4:0]  m_fd, m_done_fd;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_since = 3;
    m_add_a = 32'h0; m_add_b = 32'h0; m_res = 32'h0;
    m_fd = 5'd0; m_done_fd = 5'd0; m_done_data = 32'h0;
  endtask

  task automatic model_update();
    logic wb_now, idle_now, ext;
    logic [31:0] a, b;
    wb_now   = (m_since == 2);
    idle_now = (m_since >= 3);
    ext      = bif.ext_wr_en && !wb_now;
    if (wb_now) m_rf[m_fd] = m_res;
    if (bif.req_valid && idle_now) begin
      a = (ext && bif.ext_wr_addr == bif.req_fs) ? bif.ext_wr_data : m_rf[bif.req_fs];
      b = (ext && bif.ext_wr_addr == bif.req_ft) ? bif.ext_wr_data : m_rf[bif.req_ft];
      m_add_a = a;
      m_fd    = bif.req_fd;
      case (bif.req_op)
        2'd0:    begin m_add_b = b; m_res = ref_sum(a, b); end
        2'd1:    begin m_add_b = b ^ 32'h8000_0000; m_res = ref_sum(a, m_add_b); end
        2'd2:    m_res = a;
        default: m_res = a ^ 32'h8000_0000;
      endcase
      m_since = 0;
    end else if (m_since < 3) begin
      m_since++;
    end
    if (m_since == 2) begin
      m_done_fd   = m_fd;
      m_done_data = m_res;
    end
    if (ext) m_rf[bif.ext_wr_addr] = bif.ext_wr_data;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #3;
    chk("req_ready",    32'(bif.req_ready),    32'(m_since >= 3));
    chk("ext_wr_ready", 32'(bif.ext_wr_ready), 32'(m_since != 2));
    chk("done",         32'(bif.done),         32'(m_since == 2));
    chk("add_a",        bif.add_a,             m_add_a);
    chk("add_b",        bif.add_b,             m_add_b);
    chk("done_fd",      32'(bif.done_fd),      32'(m_done_fd));
    chk("done_data",    bif.done_data,         m_done_data);
    chk("ext_rd_data",  bif.ext_rd_data,       m_rf[bif.ext_rd_addr]);
  end

  task automatic cyc_step();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  task automatic mtc1(input int addr, input logic [31:0] data);
    bif.ext_wr_en = 1'b1; bif.ext_wr_addr = 5'(addr); bif.ext_wr_data = data;
    cyc_step();
    bif.ext_wr_en = 1'b0;
  endtask

  task automatic issue(input int op, input int fs, input int ft, input int fd);
    bif.req_valid = 1'b1; bif.req_op = 2'(op);
    bif.req_fs = 5'(fs); bif.req_ft = 5'(ft); bif.req_fd = 5'(fd);
    cyc_step();
    bif.req_valid = 1'b0; bif.ext_wr_en = 1'b0;
  endtask

  task automatic run_op(input int op, input int fs, input int ft, input int fd,
                        input logic [31:0] exp);
    issue(op, fs, ft, fd);
    bif.ext_rd_addr = 5'(fd);
    cyc_step();
    cyc_step();
    chk("lit_done", 32'(bif.done), 32'd1);
    chk("lit_done_data", bif.done_data, exp);
    cyc_step();
    chk("lit_rf", bif.ext_rd_data, exp);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h3F80_0000;
      2:       return 32'hC000_0000;
      3:       return 32'h4040_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_chk = 0; n_fail = 0;
    model_reset();
    rst_n = 1'b0;
    bif.req_valid = 1'b0; bif.req_op = 2'd0;
    bif.req_fs = 5'd0; bif.req_ft = 5'd0; bif.req_fd = 5'd0;
    bif.ext_wr_en = 1'b0; bif.ext_wr_addr = 5'd0; bif.ext_wr_data = 32'h0;
    bif.ext_rd_addr = 5'd0;
    cyc_step(); cyc_step();
    rst_n = 1'b1;
    chk("rst_req_ready", 32'(bif.req_ready), 32'd1);
    chk("rst_ext_ready", 32'(bif.ext_wr_ready), 32'd1);
    chk("rst_add_a", bif.add_a, 32'h0);
    chk("rst_done", 32'(bif.done), 32'd0);

    mtc1(1, 32'h3F80_0000);
    mtc1(2, 32'h4000_0000);
    run_op(0, 1, 2, 3, 32'h4040_0000);
    run_op(1, 3, 1, 4, 32'h4000_0000);
    chk("lit_sub_add_b", bif.add_b, 32'hBF80_0000);
    run_op(3, 1, 0, 5, 32'hBF80_0000);
    chk("lit_neg_add_b", bif.add_b, 32'hBF80_0000);
    run_op(2, 2, 0, 6, 32'h4000_0000);
    chk("lit_mov_add_b", bif.add_b, 32'hBF80_0000);

    // Forwarded MTC1 on the accept edge.
    bif.ext_wr_en = 1'b1; bif.ext_wr_addr = 5'd7; bif.ext_wr_data = 32'h4080_0000;
    run_op(0, 7, 1, 8, 32'h40A0_0000);

    // MTC1 held across WB.
    issue(0, 1, 2, 12);
    bif.ext_rd_addr = 5'd11;
    cyc_step(); cyc_step();
    bif.ext_wr_en = 1'b1; bif.ext_wr_addr = 5'd11; bif.ext_wr_data = 32'h4100_0000;
    chk("lit_wb_ext_ready", 32'(bif.ext_wr_ready), 32'd0);
    chk("lit_wb_done_data", bif.done_data, 32'h4040_0000);
    cyc_step();
    chk("lit_held_not_yet", bif.ext_rd_data, 32'h0);
    cyc_step();
    bif.ext_wr_en = 1'b0;
    chk("lit_held_landed", bif.ext_rd_data, 32'h4100_0000);
    bif.ext_rd_addr = 5'd12;
    #1;
    chk("lit_wb_intact", bif.ext_rd_data, 32'h4040_0000);

`ifdef FPU_ZERO_FLUSH_EN
    run_op(1, 1, 1, 9, 32'h0000_0000);
    run_op(0, 0, 2, 10, 32'h4000_0000);
`endif

    // Reset in CAPT aborts the writeback.
    issue(0, 1, 2, 13);
    bif.ext_rd_addr = 5'd13;
    cyc_step();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("lit_abort_ready", 32'(bif.req_ready), 32'd1);
    chk("lit_abort_done", 32'(bif.done), 32'd0);
    cyc_step(); cyc_step();
    rst_n = 1'b1;
    cyc_step(); cyc_step();
    chk("lit_abort_rf", bif.ext_rd_data, 32'h0);

    for (int i = 0; i < 600; i++) begin
      bif.req_valid   = 1'($urandom_range(0, 1));
      bif.req_op      = 2'($urandom_range(0, 3));
      bif.req_fs      = 5'($urandom_range(0, 15));
      bif.req_ft      = 5'($urandom_range(0, 15));
      bif.req_fd      = 5'($urandom_range(0, 15));
      bif.ext_wr_en   = ($urandom_range(0, 2) == 0);
      bif.ext_wr_addr = 5'($urandom_range(0, 15));
      bif.ext_wr_data = rnd_val();
      bif.ext_rd_addr = 5'($urandom_range(0, 15));
      cyc_step();
    end
    bif.req_valid = 1'b0; bif.ext_wr_en = 1'b0;
    cyc_step(); cyc_step(); cyc_step(); cyc_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
